// File: rtl/add_seq.sv
// Multi-cycle adder/subtractor: M = N*K bit operands summed one N-bit chunk per cycle.
// Optional signed-overflow output enabled by defining ADD_SEQ_OVF_EN.
module add_seq #(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N*K-1:0]   a,
  input  logic [N*K-1:0]   b,
  input  logic             cin,
  input  logic             op_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   sum,
  output logic             cout
`ifdef ADD_SEQ_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned M     = N * K;
  localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [M-1:0]       opa_q, opa_d;
  logic [M-1:0]       opb_q, opb_d;
  logic [M-1:0]       res_q, res_d;
  logic [M-1:0]       sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
`ifdef ADD_SEQ_OVF_EN
  logic               ovf_q, ovf_d;
`endif

  logic [N-1:0]       chunk_a;
  logic [N-1:0]       chunk_b;
  logic [N-1:0]       chunk_s;
  logic [N:0]         chunk_c;
  logic               last_chunk;

  // N-bit ripple-carry adder on the currently indexed chunk
  always_comb begin
    chunk_a    = opa_q[int'(idx_q)*N +: N];
    chunk_b    = opb_q[int'(idx_q)*N +: N];
    chunk_c    = '0;
    chunk_s    = '0;
    chunk_c[0] = carry_q;
    for (int i = 0; i < int'(N); i++) begin
      chunk_s[i]   = chunk_a[i] ^ chunk_b[i] ^ chunk_c[i];
      chunk_c[i+1] = (chunk_a[i] & chunk_b[i]) | (chunk_c[i] & (chunk_a[i] ^ chunk_b[i]));
    end
  end

  assign last_chunk = (idx_q == IDX_W'(K - 1));

  // Next-state and datapath update; partial sums live in res_q so sum stays stable until DONE
  always_comb begin
    state_d  = state_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    cout_d   = cout_q;
`ifdef ADD_SEQ_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          opa_d   = a;
          opb_d   = op_sub ? ~b : b;
          carry_d = op_sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[int'(idx_q)*N +: N] = chunk_s;
        carry_d = chunk_c[N];
        if (last_chunk) begin
          sum_d   = res_d;
          cout_d  = chunk_c[N];
`ifdef ADD_SEQ_OVF_EN
          ovf_d   = chunk_c[N-1] ^ chunk_c[N];
`endif
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      opa_q       <= '0;
      opb_q       <= '0;
      res_q       <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      opa_q       <= opa_d;
      opb_q       <= opb_d;
      res_q       <= res_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
`ifdef ADD_SEQ_OVF_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
`ifdef ADD_SEQ_OVF_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq.sv
// Scoreboard bench for add_seq (N=8, K=4): driver pushes expected results, monitor pops on handshake.
module tb_add_seq;

  localparam int unsigned N = 8;
  localparam int unsigned K = 4;
  localparam int unsigned M = N * K;

  typedef struct {
    logic [M-1:0] s;
    logic         c;
    logic         o;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [M-1:0] a = '0;
  logic [M-1:0] b = '0;
  logic         cin = 1'b0;
  logic         op_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [M-1:0] sum;
  logic         cout;
`ifdef ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  bit   ov_prev = 1'b0;
  exp_t exp_q[$];
  int   hs_cyc[$];

  add_seq #(.N(N), .K(K)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .op_sub(op_sub),
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
`ifdef ADD_SEQ_OVF_EN
    , .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Monitor: latency at out_valid rise, result compare on each output handshake
  always @(negedge clk) begin
    if (out_valid && !ov_prev && exp_q.size() > 0)
      chk("latency", 64'(cyc - exp_q[0].acc), 64'(K));
    ov_prev = out_valid;
    if (out_valid && out_ready) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(sum), 64'hDEAD_0000_0000);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("cout", 64'(cout), 64'(e.c));
`ifdef ADD_SEQ_OVF_EN
        chk("ovf", 64'(ovf), 64'(e.o));
`endif
      end
    end
  end

  task automatic send(input logic [M-1:0] va, input logic [M-1:0] vb, input logic vcin,
                      input logic vsub, input logic [M-1:0] es, input logic ec, input logic eo,
                      input bit push, input bit hold);
    int t = 0;
    @(posedge clk); #1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("in_ready_wait", 64'(in_ready), 64'd1);
    a = va; b = vb; cin = vcin; op_sub = vsub; in_valid = 1'b1;
    if (push) exp_q.push_back('{s: es, c: ec, o: eo, acc: 0});
    @(posedge clk); #1;
    if (push) exp_q[$].acc = cyc;
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() > 0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_cout", 64'(cout), 64'd0);
    reset = 1'b0;
    #1;
    chk("in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", 64'(in_ready), 64'd1);

    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain();
    send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 1'b0);
    send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, 32'h0000_0002, 1'b1, 1'b0, 1'b1, 1'b0);
    send(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 32'h2345_678A, 1'b0, 1'b0, 1'b1, 1'b0);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b0);
    send(32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0002, 1'b0, 1'b0, 1'b1, 1'b0);
    send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Stall in DONE: outputs hold, input pulses ignored
    out_ready = 1'b0;
    send(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 20) begin
        @(posedge clk); #1;
        t++;
      end
    end
    chk("stall_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 32'h0101_0101 * 32'(i);
      b = 32'h0000_0003;
      @(posedge clk); #1;
      chk("stall_sum", 64'(sum), 64'hFFFF_FFFF);
      chk("stall_cout", 64'(cout), 64'd0);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_out_valid_hold", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("idle_sum_held", 64'(sum), 64'hFFFF_FFFF);
    chk("stall_drained", 64'(exp_q.size()), 64'd0);

    // Reset two cycles into RUN
    send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    chk("run_sum_held", 64'(sum), 64'hFFFF_FFFF);
    chk("run_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    #1;
    chk("midrun_rst_sum", 64'(sum), 64'd0);
    chk("midrun_rst_out_valid", 64'(out_valid), 64'd0);
    chk("midrun_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    send(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 32'h0000_0030, 1'b0, 1'b0, 1'b1, 1'b0);
    wait_drain();

    // Back-to-back with in_valid and out_ready held high
    hs_cyc.delete();
    send(32'h0000_0100, 32'h0000_0200, 1'b0, 1'b0, 32'h0000_0300, 1'b0, 1'b0, 1'b1, 1'b1);
    send(32'hFFFF_0000, 32'h0001_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b1);
    send(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1, 32'hFFFF_FFFA, 1'b0, 1'b0, 1'b1, 1'b1);
    in_valid = 1'b0;
    wait_drain();
    chk("b2b_count", 64'(hs_cyc.size()), 64'd3);
    if (hs_cyc.size() == 3) begin
      chk("b2b_gap1", 64'(hs_cyc[1] - hs_cyc[0]), 64'd6);
      chk("b2b_gap2", 64'(hs_cyc[2] - hs_cyc[1]), 64'd6);
    end

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/add_seq.md
ADD_SEQ -- requirements
Module: add_seq

Interface
REQ-001 Parameter N, default 8: chunk width in bits, equal to the width of the internal N-bit ripple-carry adder datapath.
REQ-002 Parameter K, default 4: number of chunks per operand; total operand width M = N*K; K >= 1.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream operand set present.
REQ-006 in_ready  output  1  block can accept an operand set.
REQ-007 a  input  M  operand A.
REQ-008 b  input  M  operand B.
REQ-009 cin  input  1  carry-in for add.
REQ-010 op_sub  input  1  1 = compute A - B, 0 = compute A + B + cin.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 sum  output  M  result word.
REQ-014 cout  output  1  carry out of bit M-1.
REQ-015 ovf  output  1  signed overflow; exists only when ADD_SEQ_OVF_EN is defined.

Function
REQ-016 FSM states: IDLE, RUN, DONE; the block SHALL hold exactly one state at a time.
REQ-017 IDLE: in_ready=1, out_valid=0; transfer on in_valid & in_ready latches a, b (b bitwise inverted if op_sub), carry register = op_sub ? 1 : cin, chunk index = 0, next state RUN.
REQ-018 RUN: each cycle adds chunk [idx*N +: N] of the latched A and B with the carry register through the N-bit adder, writes that sum chunk into the result register, stores the adder carry-out, and increments idx.
REQ-019 RUN with idx = K-1: after the chunk write, next state DONE, cout = final carry.
REQ-020 Latency: out_valid SHALL rise exactly K cycles after the accepting edge; for K=1, one RUN cycle.
REQ-021 DONE: out_valid=1, in_ready=0; sum, cout (and ovf) held stable until out_valid & out_ready.
REQ-022 On out_valid & out_ready: next state IDLE; in_ready rises the following cycle (no same-cycle accept-while-completing).
REQ-023 in_ready=0 in RUN and DONE; a, b, cin, op_sub, in_valid ignored there.
REQ-024 sum and cout SHALL be unchanged in IDLE and RUN until the next DONE overwrites them; sum is always M bits, with the carry beyond bit M-1 reported only on cout.
REQ-025 Subtraction: sum = (A - B) mod 2^M, cout = 1 when A >= B unsigned (no borrow).

Reset
REQ-026 Reset assertion, at any time including mid-RUN, SHALL force IDLE, discard partial results, and set sum=0, cout=0, ovf=0, out_valid=0, idx=0, carry register=0.
REQ-027 in_ready SHALL be 0 while reset is asserted and 1 from the first clock edge after deassertion.

Configuration
REQ-028 Macro ADD_SEQ_OVF_EN defined: port ovf present; at the final chunk ovf = carry into bit M-1 XOR carry out of bit M-1, registered with cout and held in DONE.
REQ-029 Macro ADD_SEQ_OVF_EN undefined: no ovf port and no overflow logic; all other behaviour identical.

Verification (N=8, K=4)
REQ-030 a=0xFFFFFFFF, b=0x00000001, cin=0, op_sub=0 -> sum=0x00000000, cout=1, out_valid exactly 4 cycles after accept.
REQ-031 a=0x00000005, b=0x00000007, op_sub=1 -> sum=0xFFFFFFFE, cout=0; a=7, b=5 -> sum=0x00000002, cout=1.
REQ-032 With ADD_SEQ_OVF_EN: a=0x7FFFFFFF, b=0x00000001, add -> sum=0x80000000, ovf=1, cout=0; a=0x00000001, b=0x00000001 -> ovf=0.
REQ-033 out_ready held 0 for 10 cycles in DONE -> sum/cout stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE, in_ready=1 next cycle.
REQ-034 Reset asserted 2 cycles into RUN -> out_valid=0, sum=0 immediately; after release, new operands a=0x10, b=0x20 -> sum=0x30 in 4 cycles.
REQ-035 Back-to-back: in_valid and out_ready held 1, three operand sets -> three results in order, one every 6 cycles (accept, 4 RUN, DONE).
